// File: rtl/hazard_pkg.sv
// Shared constants for the register hazard scoreboard.
package hazard_pkg;
  localparam int NREG_DEF  = 32;
  localparam int AW        = $clog2(NREG_DEF);
  localparam int LAT_W_DEF = 3;
  localparam logic [LAT_W_DEF-1:0] CNT_LONG = '1;
  localparam int REG_ZERO  = 0;
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending/long/committed flags plus remaining-latency counter.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             issue_hit,
  input  logic             issue_long,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             long_done,
  input  logic             commit_hit,
  input  logic             wb_hit,
  input  logic             flush,
  input  logic             hold,
  output logic             busy_o,
  output logic             long_o,
  output logic [LAT_W-1:0] cnt_o
);
  logic             busy_q, busy_d;
  logic             long_q, long_d;
  logic             committed_q, committed_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    busy_d      = busy_q;
    long_d      = long_q;
    committed_d = committed_q;
    cnt_d       = cnt_q;
    if (issue_hit) begin
      busy_d      = 1'b1;
      committed_d = 1'b0;
      long_d      = issue_long;
      cnt_d       = issue_long ? {LAT_W{1'b1}} : issue_lat;
    end else if (busy_q) begin
      // A freed entry is fully scrubbed so stale long/cnt never leak into a later issue.
      if (wb_hit || (flush && !committed_q)) begin
        busy_d      = 1'b0;
        long_d      = 1'b0;
        committed_d = 1'b0;
        cnt_d       = '0;
      end else begin
        if (commit_hit) committed_d = 1'b1;
        if (long_q) begin
          if (long_done) begin
            long_d = 1'b0;
            cnt_d  = '0;
          end
        end else if (cnt_q != '0 && !hold) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q      <= 1'b0;
      long_q      <= 1'b0;
      committed_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      long_q      <= long_d;
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign long_o = long_q;
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/hazard_sb.sv
// Register scoreboard: ID-stage RAW hazard detection and bypass-ready indication.
// Optional macro HAZARD_PERF_EN adds perf_stall_cnt (hazard-caused stall cycles).
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int RD_PORTS = 2,
  parameter int LAT_W    = LAT_W_DEF,
  localparam int ADDR_W  = $clog2(NREG)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_wreg,
  input  logic [LAT_W-1:0]           issue_lat,
  input  logic                       issue_long,
  input  logic                       long_done,
  input  logic [RD_PORTS-1:0]        rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  input  logic                       commit_valid,
  input  logic [ADDR_W-1:0]          commit_reg,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_reg,
  input  logic                       except_flush,
  input  logic                       ext_stall,
  output logic                       stall_id,
  output logic                       flush_ex,
  output logic [RD_PORTS-1:0]        fwd_hit,
  output logic [NREG-1:0]            busy_vec
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);
  logic [NREG-1:0]             busy_w;
  logic [NREG-1:0]             long_w;
  logic [NREG-1:0][LAT_W-1:0]  cnt_w;
  logic [RD_PORTS-1:0]         hazard;
  logic                        hazard_any;
  logic                        issue_ok;

  // An exception flush drops any issue arriving in the same cycle.
  assign issue_ok = issue_valid && !stall_id && !except_flush &&
                    (issue_wreg != ADDR_W'(REG_ZERO));

  assign busy_w[0] = 1'b0;
  assign long_w[0] = 1'b0;
  assign cnt_w[0]  = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
    hazard_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk        (clk),
      .resetn     (resetn),
      .issue_hit  (issue_ok && (issue_wreg == ADDR_W'(gi))),
      .issue_long (issue_long),
      .issue_lat  (issue_lat),
      .long_done  (long_done),
      .commit_hit (commit_valid && (commit_reg == ADDR_W'(gi))),
      .wb_hit     (wb_valid && (wb_reg == ADDR_W'(gi))),
      .flush      (except_flush),
      .hold       (ext_stall),
      .busy_o     (busy_w[gi]),
      .long_o     (long_w[gi]),
      .cnt_o      (cnt_w[gi])
    );
  end

  for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              pend;
    assign addr        = rd_addr[gi*ADDR_W +: ADDR_W];
    assign pend        = rd_en[gi] && (addr != ADDR_W'(REG_ZERO)) && busy_w[addr];
    assign hazard[gi]  = pend && ((cnt_w[addr] != '0) || long_w[addr]);
    assign fwd_hit[gi] = pend && (cnt_w[addr] == '0) && !long_w[addr];
  end

  assign hazard_any = |hazard;
  assign stall_id   = hazard_any || ext_stall;
  assign flush_ex   = hazard_any && !ext_stall;
  assign busy_vec   = busy_w;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb perf_d = hazard_any ? perf_q + 32'd1 : perf_q;

  always_ff @(posedge clk) begin
    if (!resetn) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif
endmodule
